// File: rtl/top_module_cla4.sv
// Registered 4-bit carry-lookahead adder: {C4,SUM} = A + B + C0 from registered operands.
// Define CLA_OUT_REG_EN to add the output register stage (latency 2); otherwise latency is 1.
`timescale 1ns/1ps
module top_module_cla4 (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C0,
    output logic [3:0] SUM,
    output logic       C4
);

    localparam int unsigned W = 4;

    logic [W-1:0] a_q, b_q;
    logic         c0_q;

    logic [W-1:0] g_c, p_c;
    logic         c1_c, c2_c, c3_c, c4_c;
    logic         gg_c, gp_c;
    logic [W-1:0] sum_c;

    // Input operand capture, no enable.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_q  <= '0;
            b_q  <= '0;
            c0_q <= 1'b0;
        end else begin
            a_q  <= A;
            b_q  <= B;
            c0_q <= C0;
        end
    end

    // Flattened two-level carries; group terms give C4 without any ripple path.
    always_comb begin
        g_c  = a_q & b_q;
        p_c  = a_q ^ b_q;
        c1_c = g_c[0] | (p_c[0] & c0_q);
        c2_c = g_c[1] | (p_c[1] & g_c[0]) | (p_c[1] & p_c[0] & c0_q);
        c3_c = g_c[2] | (p_c[2] & g_c[1]) | (p_c[2] & p_c[1] & g_c[0])
             | (p_c[2] & p_c[1] & p_c[0] & c0_q);
        gg_c = g_c[3] | (p_c[3] & g_c[2]) | (p_c[3] & p_c[2] & g_c[1])
             | (p_c[3] & p_c[2] & p_c[1] & g_c[0]);
        gp_c = &p_c;
        c4_c = gg_c | (gp_c & c0_q);
        sum_c = p_c ^ {c3_c, c2_c, c1_c, c0_q};
    end

`ifdef CLA_OUT_REG_EN
    logic [W-1:0] sum_q;
    logic         c4_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sum_q <= '0;
            c4_q  <= 1'b0;
        end else begin
            sum_q <= sum_c;
            c4_q  <= c4_c;
        end
    end

    assign SUM = sum_q;
    assign C4  = c4_q;
`else
    // Outputs follow the input registers directly; still zero under reset.
    assign SUM = sum_c;
    assign C4  = c4_c;
`endif

endmodule

// File: tb/tb_top_module_cla4.sv
// Self-checking bench for top_module_cla4: directed cases plus randomized and exhaustive
// operands checked against plain A+B+C0 arithmetic delayed by the configured latency.
`timescale 1ns/1ps
module tb_top_module_cla4;

`ifdef CLA_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] A, B;
    logic       C0;
    logic [3:0] SUM;
    logic       C4;

    int checks = 0;
    int errors = 0;
    logic [4:0] pend_q[$];

    top_module_cla4 dut (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .C0(C0), .SUM(SUM), .C4(C4)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input logic [4:0] obs, input logic [4:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one operand set, let it cross an edge, compare to the result due now.
    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic c, input string tag);
        logic [4:0] exp;
        A = a; B = b; C0 = c;
        pend_q.push_back(5'(a) + 5'(b) + 5'(c));
        @(posedge CLK);
        #1;
        exp = pend_q.pop_front();
        chk({C4, SUM}, exp, tag);
    endtask

    // Hold operands for the full latency, then check against a directed constant.
    task automatic hold(input logic [3:0] a, input logic [3:0] b, input logic c,
                        input logic [4:0] exp, input string tag);
        for (int k = 0; k < LAT; k++) step(a, b, c, {tag, "_pipe"});
        chk({C4, SUM}, exp, tag);
    endtask

    // Assert reset away from the edge, expect immediate clear held across an edge.
    task automatic pulse_reset(input string tag);
        #2;
        RST = 1'b1;
        #1;
        chk({C4, SUM}, 5'd0, {tag, "_async"});
        @(posedge CLK);
        #1;
        chk({C4, SUM}, 5'd0, {tag, "_held"});
        RST = 1'b0;
        pend_q.delete();
        for (int k = 0; k < LAT - 1; k++) pend_q.push_back(5'd0);
    endtask

    initial begin
        RST = 1'b1; A = 4'hF; B = 4'hF; C0 = 1'b1;
        #1;
        chk({C4, SUM}, 5'd0, "reset_initial");
        @(posedge CLK);
        #1;
        chk({C4, SUM}, 5'd0, "reset_edge");
        RST = 1'b0;
        for (int k = 0; k < LAT - 1; k++) pend_q.push_back(5'd0);

        hold(4'hF, 4'hF, 1'b1, 5'b1_1111, "release_max");
        hold(4'b0011, 4'b0101, 1'b0, 5'b0_1000, "prop_chain");
        hold(4'b1010, 4'b1100, 1'b0, 5'b1_0110, "carry_out");
        hold(4'b0110, 4'b0011, 1'b0, 5'b0_1001, "mid_carry");
        hold(4'b1111, 4'b0000, 1'b1, 5'b1_0000, "full_prop");

        // Back-to-back operands; expected results come out in order.
        step(4'b0000, 4'b0000, 1'b0, "b2b_0");
        step(4'b1111, 4'b1111, 1'b0, "b2b_1");
        step(4'b0110, 4'b0011, 1'b0, "b2b_2");
        for (int k = 0; k < LAT; k++) step(4'b0000, 4'b0001, 1'b0, "b2b_flush");

        // Mid-cycle input glitch must not reach the outputs.
        A = 4'hF; B = 4'hF; C0 = 1'b1;
        #2;
        chk({C4, SUM}, 5'd1, "glitch_free");

        for (int i = 0; i < 64; i++)
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), "random");

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            if (i == 256) pulse_reset("reset_mid_sweep");
            step(v[3:0], v[7:4], v[8], "sweep");
        end
        for (int k = 0; k < LAT; k++) step(4'h0, 4'h0, 1'b0, "sweep_flush");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
